// File: rtl/tx_framer.sv
// tx_framer: buffers encrypted AXI-Stream words and emits header/payload/checksum frames
module tx_framer #(
  parameter int unsigned C_PAYLOAD_WORDS = 16,
  parameter int unsigned C_FIFO_DEPTH = 32,
  parameter logic [7:0] C_SYNC_BYTE = 8'hA5
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        i_enable,
  input  logic        i_clear,
  input  logic        s_axis_tvalid,
  input  logic [31:0] s_axis_tdata,
  output logic        s_axis_tready,
  output logic        m_axis_tvalid,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] o_frame_count,
  output logic        o_overflow
);
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] P_CNT = CW'(C_PAYLOAD_WORDS);
  localparam logic [CW-1:0] DEPTH = CW'(C_FIFO_DEPTH);
  localparam logic [7:0] P8 = 8'(C_PAYLOAD_WORDS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR = 2'd1;
  localparam logic [1:0] S_PAY = 2'd2;
  localparam logic [1:0] S_CHK = 2'd3;
  logic [31:0] mem [C_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [1:0] state;
  logic [7:0] beat;
  logic [15:0] seq, hdr_seq;
  logic [31:0] sum, hdr, head;
  logic wr, rd, hs, go, elig;
  // Handshakes, FIFO pop and frame-start decisions; the header after a checksum carries the next sequence number
  always_comb begin
    wr = s_axis_tvalid && s_axis_tready;
    hs = m_axis_tvalid && m_axis_tready;
    elig = i_enable && (fifo_count >= P_CNT);
    go = elig && ((state == S_IDLE) || (state == S_CHK && hs));
    rd = hs && ((state == S_HDR) || (state == S_PAY && beat != P8));
    hdr_seq = (state == S_CHK) ? seq + 16'd1 : seq;
    hdr = {C_SYNC_BYTE, P8, hdr_seq};
    head = mem[rd_ptr];
  end
  assign s_axis_tready = (fifo_count != DEPTH);
  // FIFO storage; a full FIFO never accepts a write, so the slot being read is never overwritten
  always_ff @(posedge s_axi_aclk)
    if (wr) mem[wr_ptr] <= s_axis_tdata;
  // FIFO pointers, occupancy and sticky overflow on words offered while full
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= (wr && !rd) ? fifo_count + 1'b1 : (!wr && rd) ? fifo_count - 1'b1 : fifo_count;
      if (i_clear) o_overflow <= 1'b0;
      else if (s_axis_tvalid && !s_axis_tready) o_overflow <= 1'b1;
    end
  // Framing FSM driving the output register; state names the word currently presented
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      state <= S_IDLE;
      beat <= '0;
      seq <= '0;
      sum <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      o_frame_count <= '0;
    end else begin
      if (i_clear) o_frame_count <= '0;
      else if (hs && state == S_CHK) o_frame_count <= o_frame_count + 16'd1;
      if (hs && state == S_CHK) seq <= seq + 16'd1;
      if (go) begin
        state <= S_HDR;
        m_axis_tvalid <= 1'b1;
        m_axis_tdata <= hdr;
        m_axis_tlast <= 1'b0;
        sum <= hdr;
      end else if (hs) begin
        if (rd) begin
          state <= S_PAY;
          m_axis_tdata <= head;
          sum <= sum + head;
          beat <= (state == S_HDR) ? 8'd1 : beat + 8'd1;
        end else if (state == S_PAY) begin
          state <= S_CHK;
          m_axis_tdata <= sum;
          m_axis_tlast <= 1'b1;
        end else begin
          state <= S_IDLE;
          m_axis_tvalid <= 1'b0;
          m_axis_tdata <= '0;
          m_axis_tlast <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_tx_framer.sv
// tb_tx_framer: directed checks of framing, backpressure, overflow, enable and sequence wrap
module tb_tx_framer;
  logic clk = 0, rstn = 0, en = 0, clr = 0, s_v = 0;
  logic [31:0] s_d = 0;
  logic s_r, m_v, m_l, m_r, ovf;
  logic [31:0] m_d;
  logic [15:0] fc;
  logic fix_r = 1, rnd = 0, rnd_r = 0;
  int tests = 0, fails = 0, cyc = 0;
  logic [31:0] q_d[$];
  logic q_l[$];
  int q_c[$];
  logic pv = 0, pr = 0, pl = 0;
  logic [31:0] pd = 0;

  assign m_r = rnd ? rnd_r : fix_r;

  tx_framer #(.C_PAYLOAD_WORDS(4), .C_FIFO_DEPTH(32), .C_SYNC_BYTE(8'hA5)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn), .i_enable(en), .i_clear(clr),
    .s_axis_tvalid(s_v), .s_axis_tdata(s_d), .s_axis_tready(s_r),
    .m_axis_tvalid(m_v), .m_axis_tdata(m_d), .m_axis_tlast(m_l), .m_axis_tready(m_r),
    .o_frame_count(fc), .o_overflow(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    rnd_r = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pv && !pr) begin
      chk("stall_valid", 32'(m_v), 32'd1);
      chk("stall_data", m_d, pd);
      chk("stall_last", 32'(m_l), 32'(pl));
    end
    if (m_v && m_r) begin
      q_d.push_back(m_d);
      q_l.push_back(m_l);
      q_c.push_back(cyc);
    end
    pv = m_v;
    pr = m_r;
    pd = m_d;
    pl = m_l;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    s_v = 1;
    s_d = v;
    step(1);
    s_v = 0;
  endtask

  task automatic push_run(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) push(v + 32'(i));
  endtask

  task automatic qclear();
    q_d.delete();
    q_l.delete();
    q_c.delete();
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (q_d.size() < n && k < 400) begin
      step(1);
      k++;
    end
    if (q_d.size() < n) chk("timeout_beats", 32'(q_d.size()), 32'(n));
  endtask

  task automatic check_frame(input int b, input logic [15:0] s, input logic [31:0] v);
    logic [31:0] h, sum, e;
    h = {8'hA5, 8'h04, s};
    sum = h;
    for (int i = 0; i < 6; i++) begin
      e = (i == 0) ? h : (i == 5) ? sum : v + 32'(i - 1);
      if (i > 0 && i < 5) sum = sum + e;
      if (b + i < q_d.size()) begin
        chk($sformatf("beat%0d_data", b + i), q_d[b + i], e);
        chk($sformatf("beat%0d_last", b + i), 32'(q_l[b + i]), 32'(i == 5));
      end else chk($sformatf("beat%0d_missing", b + i), 32'(q_d.size()), 32'(b + i + 1));
    end
  endtask

  initial begin
    step(3);
    chk("rst_tvalid", 32'(m_v), 32'd0);
    chk("rst_tlast", 32'(m_l), 32'd0);
    chk("rst_tdata", m_d, 32'd0);
    chk("rst_count", 32'(fc), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_sready", 32'(s_r), 32'd1);
    rstn = 1;
    step(2);
    en = 1;
    push_run(32'd1, 4);
    wait_beats(6);
    check_frame(0, 16'h0000, 32'd1);
    step(1);
    chk("count_1", 32'(fc), 32'd1);
    qclear();
    push_run(32'd11, 8);
    wait_beats(12);
    check_frame(0, 16'h0001, 32'd11);
    check_frame(6, 16'h0002, 32'd15);
    for (int i = 1; i < 12 && i < q_c.size(); i++)
      chk($sformatf("gap%0d", i), 32'(q_c[i] - q_c[i - 1]), 32'd1);
    chk("count_3", 32'(fc), 32'd3);
    qclear();
    rnd = 1;
    push_run(32'd21, 8);
    wait_beats(12);
    check_frame(0, 16'h0003, 32'd21);
    check_frame(6, 16'h0004, 32'd25);
    chk("rand_no_extra", 32'(q_d.size()), 32'd12);
    rnd = 0;
    chk("count_5", 32'(fc), 32'd5);
    en = 0;
    fix_r = 0;
    qclear();
    push_run(32'd100, 32);
    chk("full_sready", 32'(s_r), 32'd0);
    chk("full_no_ovf", 32'(ovf), 32'd0);
    push(32'd132);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_sready", 32'(s_r), 32'd0);
    clr = 1;
    step(1);
    clr = 0;
    chk("ovf_clear", 32'(ovf), 32'd0);
    chk("count_clear", 32'(fc), 32'd0);
    en = 1;
    fix_r = 1;
    wait_beats(48);
    for (int f = 0; f < 8; f++) check_frame(6 * f, 16'(5 + f), 32'(100 + 4 * f));
    step(2);
    chk("drain_count", 32'(fc), 32'd8);
    chk("drain_no_extra", 32'(q_d.size()), 32'd48);
    qclear();
    push_run(32'd200, 4);
    wait_beats(3);
    en = 0;
    wait_beats(6);
    check_frame(0, 16'd13, 32'd200);
    push_run(32'd204, 4);
    step(30);
    chk("dis_no_frame", 32'(q_d.size()), 32'd6);
    chk("dis_tvalid", 32'(m_v), 32'd0);
    chk("dis_count", 32'(fc), 32'd9);
    force dut.seq = 16'hFFFF;
    step(1);
    release dut.seq;
    qclear();
    en = 1;
    wait_beats(6);
    check_frame(0, 16'hFFFF, 32'd204);
    push_run(32'd300, 4);
    wait_beats(12);
    check_frame(6, 16'h0000, 32'd300);
    step(2);
    chk("wrap_count", 32'(fc), 32'd11);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
